// File: rtl/ext_pkg.sv
// Shared definitions for the immediate-extension unit: mode encoding and
// default widths used by ext_core and ext_unit.
package ext_pkg;

  // Extension modes, sampled together with the immediate.
  typedef enum logic [1:0] {
    EXT_SIGN   = 2'd0,
    EXT_ZERO   = 2'd1,
    EXT_UPPER  = 2'd2,
    EXT_BRANCH = 2'd3
  } ext_mode_e;

  // Default widths: 16-bit immediates widened to a 32-bit datapath.
  localparam int EXT_IN_W  = 16;
  localparam int EXT_OUT_W = 32;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extender: widens din to OUT_W bits according to
// mode. Holds no state; ext_unit registers its result.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = EXT_IN_W,
  parameter int OUT_W = EXT_OUT_W
) (
  input  logic [IN_W-1:0]  din,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] dout
);

  // Sign- and zero-extended views. OUT_W > IN_W always holds because the
  // top level enforces OUT_W >= 2*IN_W with IN_W >= 2.
  logic signed [OUT_W-1:0] sext;
  logic        [OUT_W-1:0] zext;

  assign sext = {{(OUT_W-IN_W){din[IN_W-1]}}, din};
  assign zext = {{(OUT_W-IN_W){1'b0}}, din};

  // Mode select. UPPER shifts the zero-extended value, so bits above
  // 2*IN_W stay zero. BRANCH drops the top two sign bits in the shift.
  always_comb begin
    dout = '0;
    case (ext_mode_e'(mode))
      EXT_SIGN:   dout = sext;
      EXT_ZERO:   dout = zext;
      EXT_UPPER:  dout = zext << IN_W;
      EXT_BRANCH: dout = sext <<< 2;
      default:    dout = sext;
    endcase
  end

endmodule

// File: rtl/ext_unit.sv
// Pipelined immediate-extension unit. The extension runs on the input
// side; finished results go into an output register (OR) and a one-entry
// skid register (SK). in_ready depends only on SK occupancy, so there is
// no combinational path from out_ready to in_ready or from in_valid to
// out_valid.
module ext_unit
  import ext_pkg::*;
#(
  parameter int IN_W  = EXT_IN_W,
  parameter int OUT_W = EXT_OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  // Reject parameter sets the extension modes cannot represent.
  if (IN_W < 2) begin : g_in_w_check
    $error("ext_unit: IN_W must be at least 2");
  end
  if (OUT_W < 2 * IN_W) begin : g_out_w_check
    $error("ext_unit: OUT_W must be at least 2*IN_W");
  end

  logic [OUT_W-1:0] ext_p0;
  logic             or_vld_p1;
  logic [OUT_W-1:0] or_data_p1;
  logic             sk_vld_p1;
  logic [OUT_W-1:0] sk_data_p1;
  logic             accept;
  logic             or_free;

  // ---- stage p0: extend the immediate before it is stored ----
  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .din  (in_data),
    .mode (in_mode),
    .dout (ext_p0)
  );

  // ---- stage p1: output and skid registers ----
  assign in_ready  = !sk_vld_p1;
  assign accept    = in_valid && in_ready;
  assign or_free   = !or_vld_p1 || out_ready;
  assign out_valid = or_vld_p1;
  assign out_data  = or_data_p1;

  // Occupancy control: refill OR from SK first, then from a new accept;
  // park an accept in SK when OR is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      or_vld_p1 <= 1'b0;
      sk_vld_p1 <= 1'b0;
    end else if (or_free) begin
      if (sk_vld_p1) begin
        or_vld_p1 <= 1'b1;
        sk_vld_p1 <= 1'b0;
      end else begin
        or_vld_p1 <= accept;
      end
    end else if (accept) begin
      sk_vld_p1 <= 1'b1;
    end
  end

  // Result storage. Cleared on reset so no stale value is visible
  // afterwards; OR data is untouched while stalled, keeping out_data stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      or_data_p1 <= '0;
      sk_data_p1 <= '0;
    end else if (or_free) begin
      if (sk_vld_p1) begin
        or_data_p1 <= sk_data_p1;
      end else if (accept) begin
        or_data_p1 <= ext_p0;
      end
    end else if (accept) begin
      sk_data_p1 <= ext_p0;
    end
  end

endmodule
